trap_ctrl: RTL and testbench

//   Initiator side of the CSR trap interface. Collects exception and MRET requests from the IF and ID stages.

---
 rtl/trap_ctrl_pkg.sv | 14 +
 rtl/trap_prio_enc.sv | 47 ++++
 rtl/trap_ctrl.sv | 131 +++++++++++++
 tb/tb_trap_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap controller: exception cause codes and FSM state encoding.
package trap_ctrl_pkg;

  localparam logic [1:0] ILLEGAL_IR          = 2'd0;
  localparam logic [1:0] I_ADDR_MISALIGNMENT = 2'd1;
  localparam logic [1:0] ECALL               = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder for IF/ID trap requests; the ID instruction is older, so it wins.
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic        if_misalign,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_target,
  input  logic        id_illegal,
  input  logic        id_ecall,
  input  logic        id_mret,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_ir,
  output logic        req_valid_o,
  output logic        is_mret_req_o,
  output logic [1:0]  cause_o,
  output logic [31:0] pc_o,
  output logic [31:0] tval_o
);

  always_comb begin
    req_valid_o   = 1'b0;
    is_mret_req_o = 1'b0;
    cause_o       = ILLEGAL_IR;
    pc_o          = 32'h0;
    tval_o        = 32'h0;
    if (id_illegal) begin
      req_valid_o = 1'b1;
      cause_o     = ILLEGAL_IR;
      pc_o        = id_pc;
      tval_o      = id_ir;
    end else if (id_ecall) begin
      req_valid_o = 1'b1;
      cause_o     = ECALL;
      pc_o        = id_pc;
    end else if (id_mret) begin
      req_valid_o   = 1'b1;
      is_mret_req_o = 1'b1;
      pc_o          = id_pc;
    end else if (if_misalign) begin
      req_valid_o = 1'b1;
      cause_o     = I_ADDR_MISALIGNMENT;
      pc_o        = if_pc;
      tval_o      = if_target;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: commit pulse to the CSR file, pipeline flush window, then one PC redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_misalign,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_target,
  input  logic        id_illegal,
  input  logic        id_ecall,
  input  logic        id_mret,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_ir,
  input  logic [31:0] trap_vector_addr,
  input  logic [31:0] mepc,
  output logic        e_raised,
  output logic [1:0]  e_cause,
  output logic [31:0] e_pc,
  output logic [31:0] e_tval,
  output logic        is_mret,
  output logic        flush_n,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  logic        req_valid;
  logic        is_mret_req;
  logic [1:0]  req_cause;
  logic [31:0] req_pc;
  logic [31:0] req_tval;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        e_raised_q;
  logic        is_mret_q;
  logic        redirect_valid_q;
  logic        busy_q;
  logic        flush_n_q;
  logic [1:0]  e_cause_q;
  logic [31:0] e_pc_q;
  logic [31:0] e_tval_q;
  logic [31:0] redirect_pc_q;

  trap_prio_enc u_prio_enc (
    .if_misalign   (if_misalign),
    .if_pc         (if_pc),
    .if_target     (if_target),
    .id_illegal    (id_illegal),
    .id_ecall      (id_ecall),
    .id_mret       (id_mret),
    .id_pc         (id_pc),
    .id_ir         (id_ir),
    .req_valid_o   (req_valid),
    .is_mret_req_o (is_mret_req),
    .cause_o       (req_cause),
    .pc_o          (req_pc),
    .tval_o        (req_tval)
  );

  // Redirect target is captured at the IDLE sample so CSR writes during COMMIT cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= 4'h0;
      e_raised_q       <= 1'b0;
      is_mret_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      flush_n_q        <= 1'b1;
      e_cause_q        <= ILLEGAL_IR;
      e_pc_q           <= 32'h0;
      e_tval_q         <= 32'h0;
      redirect_pc_q    <= 32'h0;
    end else begin
      e_raised_q       <= 1'b0;
      is_mret_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q       <= COMMIT;
            busy_q        <= 1'b1;
            flush_n_q     <= 1'b0;
            redirect_pc_q <= is_mret_req ? mepc : trap_vector_addr;
            if (is_mret_req) begin
              is_mret_q <= 1'b1;
            end else begin
              e_raised_q <= 1'b1;
              e_cause_q  <= req_cause;
              e_pc_q     <= req_pc;
              e_tval_q   <= req_tval;
            end
          end
        end
        COMMIT: begin
          state_q          <= FLUSH;
          cnt_q            <= FLUSH_INIT;
          redirect_valid_q <= (FLUSH_INIT == 4'h0);
        end
        FLUSH: begin
          if (cnt_q == 4'h0) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            flush_n_q <= 1'b1;
          end else begin
            cnt_q            <= cnt_q - 4'h1;
            redirect_valid_q <= (cnt_q == 4'h1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign e_raised       = e_raised_q;
  assign e_cause        = e_cause_q;
  assign e_pc           = e_pc_q;
  assign e_tval         = e_tval_q;
  assign is_mret        = is_mret_q;
  assign flush_n        = flush_n_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: sequence-position reference model plus directed literal checks.
module tb_trap_ctrl;

  localparam int FC = 2;
  localparam logic [1:0] C_ILL   = 2'd0;
  localparam logic [1:0] C_MIS   = 2'd1;
  localparam logic [1:0] C_ECALL = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        if_misalign;
  logic [31:0] if_pc;
  logic [31:0] if_target;
  logic        id_illegal;
  logic        id_ecall;
  logic        id_mret;
  logic [31:0] id_pc;
  logic [31:0] id_ir;
  logic [31:0] trap_vector_addr;
  logic [31:0] mepc;
  logic        e_raised;
  logic [1:0]  e_cause;
  logic [31:0] e_pc;
  logic [31:0] e_tval;
  logic        is_mret;
  logic        flush_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  trap_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_misalign      (if_misalign),
    .if_pc            (if_pc),
    .if_target        (if_target),
    .id_illegal       (id_illegal),
    .id_ecall         (id_ecall),
    .id_mret          (id_mret),
    .id_pc            (id_pc),
    .id_ir            (id_ir),
    .trap_vector_addr (trap_vector_addr),
    .mepc             (mepc),
    .e_raised         (e_raised),
    .e_cause          (e_cause),
    .e_pc             (e_pc),
    .e_tval           (e_tval),
    .is_mret          (is_mret),
    .flush_n          (flush_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current trap sequence (0 = idle, 1 = commit, FC+1 = redirect).
  int          mPos    = 0;
  bit          mRet    = 1'b0;
  logic [1:0]  mCause  = C_ILL;
  logic [31:0] mPc     = 32'h0;
  logic [31:0] mTval   = 32'h0;
  logic [31:0] mTarget = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPos = 0; mRet = 1'b0; mCause = C_ILL; mPc = 32'h0; mTval = 32'h0; mTarget = 32'h0;
    end else if (mPos == 0) begin
      if (id_illegal) begin
        mPos = 1; mRet = 1'b0; mCause = C_ILL; mPc = id_pc; mTval = id_ir; mTarget = trap_vector_addr;
      end else if (id_ecall) begin
        mPos = 1; mRet = 1'b0; mCause = C_ECALL; mPc = id_pc; mTval = 32'h0; mTarget = trap_vector_addr;
      end else if (id_mret) begin
        mPos = 1; mRet = 1'b1; mTarget = mepc;
      end else if (if_misalign) begin
        mPos = 1; mRet = 1'b0; mCause = C_MIS; mPc = if_pc; mTval = if_target; mTarget = trap_vector_addr;
      end
    end else if (mPos == FC + 1) begin
      mPos = 0;
    end else begin
      mPos = mPos + 1;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_busy",     32'(busy),           32'(mPos != 0));
      checkOutput("m_flush_n",  32'(flush_n),        32'(mPos == 0));
      checkOutput("m_e_raised", 32'(e_raised),       32'(mPos == 1 && !mRet));
      checkOutput("m_is_mret",  32'(is_mret),        32'(mPos == 1 && mRet));
      checkOutput("m_redirect", 32'(redirect_valid), 32'(mPos == FC + 1));
      checkOutput("m_e_cause",  32'(e_cause),        32'(mCause));
      checkOutput("m_e_pc",     e_pc,                mPc);
      checkOutput("m_e_tval",   e_tval,              mTval);
      checkOutput("m_redir_pc", redirect_pc,         mTarget);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clearReqs();
    id_illegal  = 1'b0;
    id_ecall    = 1'b0;
    id_mret     = 1'b0;
    if_misalign = 1'b0;
  endtask

  task automatic applyStimulus(input bit ill, input bit ecall, input bit mret, input bit mis,
                               input logic [31:0] idPc, input logic [31:0] idIr,
                               input logic [31:0] ifPc, input logic [31:0] ifTgt,
                               input logic [31:0] tva, input logic [31:0] mepcV);
    id_illegal       = ill;
    id_ecall         = ecall;
    id_mret          = mret;
    if_misalign      = mis;
    id_pc            = idPc;
    id_ir            = idIr;
    if_pc            = ifPc;
    if_target        = ifTgt;
    trap_vector_addr = tva;
    mepc             = mepcV;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nRaise;
    int nMret;
    int nRedir;
    rst_n = 1'b1;
    clearReqs();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #2 checkEn = 1'b1;
    tick(2);
    checkOutput("rst_flush_n",  32'(flush_n),        32'd1);
    checkOutput("rst_busy",     32'(busy),           32'd0);
    checkOutput("rst_e_cause",  32'(e_cause),        32'(C_ILL));
    checkOutput("rst_redirect", 32'(redirect_valid), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Illegal instruction trap
    applyStimulus(1, 0, 0, 0, 32'h0001_0040, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0001_0800, 32'h0);
    tick(1);
    checkOutput("ill_e_raised", 32'(e_raised), 32'd1);
    checkOutput("ill_e_cause",  32'(e_cause),  32'(C_ILL));
    checkOutput("ill_e_tval",   e_tval,        32'hFFFF_FFFF);
    checkOutput("ill_e_pc",     e_pc,          32'h0001_0040);
    checkOutput("ill_flush1",   32'(flush_n),  32'd0);
    clearReqs();
    tick(1);
    checkOutput("ill_flush2",   32'(flush_n),        32'd0);
    checkOutput("ill_redir_early", 32'(redirect_valid), 32'd0);
    tick(1);
    checkOutput("ill_flush3",   32'(flush_n),        32'd0);
    checkOutput("ill_redirect", 32'(redirect_valid), 32'd1);
    checkOutput("ill_redir_pc", redirect_pc,         32'h0001_0800);
    tick(1);
    checkOutput("ill_flush_end", 32'(flush_n), 32'd1);
    checkOutput("ill_busy_end",  32'(busy),    32'd0);

    // ECALL trap
    applyStimulus(0, 1, 0, 0, 32'h0001_0100, 32'h0000_0073, 32'h0, 32'h0, 32'h0001_0800, 32'h0);
    tick(1);
    checkOutput("ecall_cause", 32'(e_cause), 32'(C_ECALL));
    checkOutput("ecall_pc",    e_pc,         32'h0001_0100);
    checkOutput("ecall_tval",  e_tval,       32'h0);
    clearReqs();
    tick(3);

    // MRET with mepc changing during COMMIT
    applyStimulus(0, 0, 1, 0, 32'h0001_0200, 32'h3020_0073, 32'h0, 32'h0, 32'h0001_0800, 32'h0001_0104);
    tick(1);
    checkOutput("mret_pulse",    32'(is_mret),  32'd1);
    checkOutput("mret_e_raised", 32'(e_raised), 32'd0);
    clearReqs();
    mepc = 32'h0;
    tick(1);
    checkOutput("mret_pulse_end", 32'(is_mret), 32'd0);
    tick(1);
    checkOutput("mret_redirect", 32'(redirect_valid), 32'd1);
    checkOutput("mret_redir_pc", redirect_pc,         32'h0001_0104);
    tick(1);

    // Simultaneous illegal + MRET + misalign: only the illegal trap commits
    applyStimulus(1, 0, 1, 1, 32'h0001_0300, 32'hDEAD_BEEF, 32'h0001_0304, 32'h0001_0306, 32'h0001_0800, 32'h0001_0104);
    nRaise = 0; nMret = 0; nRedir = 0;
    tick(1);
    nRaise += int'(e_raised); nMret += int'(is_mret); nRedir += int'(redirect_valid);
    clearReqs();
    for (int i = 0; i < 5; i++) begin
      tick(1);
      nRaise += int'(e_raised); nMret += int'(is_mret); nRedir += int'(redirect_valid);
    end
    checkOutput("simul_raise_cnt", 32'(nRaise), 32'd1);
    checkOutput("simul_mret_cnt",  32'(nMret),  32'd0);
    checkOutput("simul_redir_cnt", 32'(nRedir), 32'd1);
    checkOutput("simul_cause",     32'(e_cause), 32'(C_ILL));
    checkOutput("simul_tval",      e_tval,       32'hDEAD_BEEF);

    // Fetch misalignment
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0, 32'h0001_0010, 32'h0001_0022, 32'h0001_0880, 32'h0);
    tick(1);
    checkOutput("mis_cause", 32'(e_cause), 32'(C_MIS));
    checkOutput("mis_pc",    e_pc,         32'h0001_0010);
    checkOutput("mis_tval",  e_tval,       32'h0001_0022);
    clearReqs();
    tick(3);

    // Held request re-triggers two cycles after the redirect
    applyStimulus(0, 1, 0, 0, 32'h0001_0400, 32'h0, 32'h0, 32'h0, 32'h0001_0800, 32'h0);
    tick(3);
    checkOutput("b2b_redirect", 32'(redirect_valid), 32'd1);
    tick(1);
    checkOutput("b2b_idle_busy",  32'(busy),     32'd0);
    checkOutput("b2b_idle_raise", 32'(e_raised), 32'd0);
    tick(1);
    checkOutput("b2b_recommit", 32'(e_raised), 32'd1);
    clearReqs();
    tick(3);

    // Reset during FLUSH aborts without a redirect
    applyStimulus(0, 1, 0, 0, 32'h0001_0500, 32'h0, 32'h0, 32'h0, 32'h0001_0900, 32'h0);
    tick(1);
    clearReqs();
    tick(1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",     32'(busy),           32'd0);
    checkOutput("abort_flush_n",  32'(flush_n),        32'd1);
    checkOutput("abort_redirect", 32'(redirect_valid), 32'd0);
    checkOutput("abort_e_pc",     e_pc,                32'h0);
    tick(1);
    checkOutput("abort_no_redir", 32'(redirect_valid), 32'd0);
    rst_n = 1'b1;
    tick(1);
    applyStimulus(0, 1, 0, 0, 32'h0001_0600, 32'h0, 32'h0, 32'h0, 32'h0001_0A00, 32'h0);
    tick(1);
    checkOutput("post_rst_raise", 32'(e_raised), 32'd1);
    checkOutput("post_rst_pc",    e_pc,          32'h0001_0600);
    clearReqs();
    tick(2);
    checkOutput("post_rst_redirect", 32'(redirect_valid), 32'd1);
    checkOutput("post_rst_redir_pc", redirect_pc,         32'h0001_0A00);
    tick(2);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
